coin_acceptor: RTL

//  Front-end stage feeding the vending-machine FSM (VM). Synchronises and qualifies raw coin-sensor
//  and cancel-button inputs, classifies each coin by pulse width, buffers accepted coins in a small

---
 rtl/vm_pkg.sv | 10 +
 rtl/coin_acceptor_if.sv | 15 +
 rtl/coin_fifo.sv | 39 +++
 rtl/coin_acceptor.sv | 113 +++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// vm_pkg: coin codes and classifier states shared with the vending-machine FSM
package vm_pkg;
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_A = 2'b01;
  localparam logic [1:0] COIN_B = 2'b10;
  typedef enum logic [1:0] {IDLE, MEAS, ACCEPT, JAM} cls_state_t;
  function automatic logic [1:0] slot_code(input logic b);
    return b ? COIN_B : COIN_A;
  endfunction
endpackage

// File: rtl/coin_acceptor_if.sv
// coin_acceptor_if: sensor inputs and VM-facing outputs of the coin acceptor
interface coin_acceptor_if #(parameter int DEPTH = 4);
  logic coin_a_raw, coin_b_raw, cancel_raw, accept_en;
  logic [1:0] coin;
  logic cancel, reject, jam;
  logic [$clog2(DEPTH):0] fifo_count;
  modport master (
    output coin_a_raw, coin_b_raw, cancel_raw, accept_en,
    input coin, cancel, reject, jam, fifo_count
  );
  modport slave (
    input coin_a_raw, coin_b_raw, cancel_raw, accept_en,
    output coin, cancel, reject, jam, fifo_count
  );
endinterface

// File: rtl/coin_fifo.sv
// coin_fifo: small FIFO of accepted coin codes awaiting emission
module coin_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic [1:0] din,
  input  logic pop,
  output logic [1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign dout = mem[rp];
  // storage write; contents need no reset since count gates every read
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wr ? wp + 1'b1 : wp;
      rp <= rd ? rp + 1'b1 : rp;
      count <= count + CW'(wr) - CW'(rd);
    end
endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: qualifies coin/cancel sensors, classifies coins by width and paces codes to VM
module coin_acceptor
  import vm_pkg::*;
#(
  parameter int MIN_W = 4,
  parameter int MAX_W = 64,
  parameter int GAP = 2,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic reset,
  coin_acceptor_if.slave bus
);
  localparam int WW = $clog2(MAX_W + 2);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = $clog2(MIN_W + 1);
  localparam int GW = $clog2(GAP + 2);
  logic [2:0] s1, s2;
  logic a_s, b_s, c_s, meas_hi, other;
  cls_state_t st;
  logic [1:0] slot, coin, dout;
  logic [WW-1:0] w;
  logic [DW-1:0] clr, cc;
  logic [GW-1:0] gap;
  logic [CW-1:0] count;
  logic pend, press, fire, push, pop, full, empty, reject, jam, cancel;
  assign {c_s, b_s, a_s} = s2;
  assign meas_hi = slot == COIN_A ? a_s : b_s;
  assign other = slot == COIN_A ? b_s : a_s;
  assign push = st == ACCEPT && bus.accept_en && !full;
  assign pop = gap == '0 && !empty;
  assign press = c_s && cc == DW'(MIN_W - 1);
  assign fire = pend && gap == '0 && empty && !push;
  assign bus.coin = coin;
  assign bus.cancel = cancel;
  assign bus.reject = reject;
  assign bus.jam = jam;
  assign bus.fifo_count = count;
  coin_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .din(slot), .pop(pop),
    .dout(dout), .full(full), .empty(empty), .count(count)
  );
  // two-flop synchronisers for the asynchronous sensors and button
  always_ff @(posedge clk) begin
    s1 <= reset ? '0 : {bus.cancel_raw, bus.coin_b_raw, bus.coin_a_raw};
    s2 <= reset ? '0 : s1;
  end
  // classifier: measures the high time of one slot, rejects glitches and jams
  always_ff @(posedge clk)
    if (reset) begin
      st <= IDLE;
      slot <= COIN_NONE;
      w <= '0;
      clr <= '0;
      reject <= 1'b0;
      jam <= 1'b0;
    end else begin
      reject <= 1'b0;
      case (st)
        IDLE:
          if (a_s && b_s) begin
            st <= JAM;
            reject <= 1'b1;
            jam <= 1'b1;
            clr <= '0;
          end else if (a_s || b_s) begin
            st <= MEAS;
            slot <= slot_code(!a_s);
            w <= WW'(1);
          end
        MEAS:
          if (other || (meas_hi && w >= WW'(MAX_W))) begin
            st <= JAM;
            reject <= 1'b1;
            jam <= 1'b1;
            clr <= '0;
            w <= WW'(MAX_W + 1);
          end else if (!meas_hi) begin
            st <= w >= WW'(MIN_W) ? ACCEPT : IDLE;
            reject <= w < WW'(MIN_W);
          end else
            w <= w + 1'b1;
        ACCEPT: begin
          st <= IDLE;
          reject <= !push;
        end
        JAM:
          if (a_s || b_s)
            clr <= '0;
          else if (clr == DW'(MIN_W - 1)) begin
            st <= IDLE;
            jam <= 1'b0;
          end else
            clr <= clr + 1'b1;
        default: st <= IDLE;
      endcase
    end
  // emitter and cancel: one code per GAP+1 cycles, cancel only once all credit has drained
  always_ff @(posedge clk)
    if (reset) begin
      coin <= COIN_NONE;
      cancel <= 1'b0;
      gap <= '0;
      pend <= 1'b0;
      cc <= '0;
    end else begin
      cc <= !c_s ? '0 : (cc == DW'(MIN_W) ? cc : cc + 1'b1);
      coin <= pop ? dout : COIN_NONE;
      gap <= pop ? GW'(GAP) : (gap != '0 ? gap - 1'b1 : gap);
      cancel <= fire;
      pend <= press | (pend & ~fire);
    end
endmodule
